// File: rtl/simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// simple_bus_arbiter
//
// Round-robin arbiter and transaction sequencer. Shares one simple_bus-style
// address/data path between NUM_MASTERS requesters and two slaves that split
// the address space at SPLIT_ADDR. One master is granted at a time; its
// request is latched onto the bus, the addressed slave gets a one-cycle start
// pulse, and once that slave reports rdy the master receives a one-cycle done
// pulse (with read data for reads).
//
// Optional feature macro: SIMPLE_BUS_ARB_TIMEOUT_EN
//   When defined, a WAIT-state watchdog ends a transaction with an error after
//   TIMEOUT_CYCLES cycles without rdy from the selected slave.
//   When undefined, WAIT holds until rdy and m_err is raised only for mode 11.
//
// Ports
//   clk        in   1                bus clock, all logic on posedge
//   rst_n      in   1                synchronous active-low reset
//   m_req      in   NUM_MASTERS      per-master request, held until m_done
//   m_addr     in   8*NUM_MASTERS    per-master address, master i at [8i+7:8i]
//   m_mode     in   2*NUM_MASTERS    per-master mode: 01 read, 10 write,
//                                    00 ignored, 11 illegal (error completion)
//   m_wdata    in   8*NUM_MASTERS    per-master write data
//   m_gnt      out  NUM_MASTERS      one-hot grant, high from GRANT to DONE
//   m_done     out  NUM_MASTERS      one-cycle completion pulse
//   m_err      out  NUM_MASTERS      qualifies m_done: transaction failed
//   m_rdata    out  8                read data, valid with m_done
//   bus_addr   out  8                latched address of the granted master
//   bus_mode   out  2                latched mode
//   bus_wdata  out  8                latched write data
//   bus_start  out  2                one-hot start pulse to slave 0/1
//   bus_rdy    in   2                per-slave completion
//   bus_rdata  in   8                slave read data, sampled with bus_rdy
//   busy       out  1                high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module simple_bus_arbiter #(
   parameter int         NUM_MASTERS    = 4,
   parameter logic [7:0] SPLIT_ADDR     = 8'd128,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_MASTERS-1:0]   m_req,
   input  logic [8*NUM_MASTERS-1:0] m_addr,
   input  logic [2*NUM_MASTERS-1:0] m_mode,
   input  logic [8*NUM_MASTERS-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]   m_gnt,
   output logic [NUM_MASTERS-1:0]   m_done,
   output logic [NUM_MASTERS-1:0]   m_err,
   output logic [7:0]               m_rdata,
   output logic [7:0]               bus_addr,
   output logic [1:0]               bus_mode,
   output logic [7:0]               bus_wdata,
   output logic [1:0]               bus_start,
   input  logic [1:0]               bus_rdy,
   input  logic [7:0]               bus_rdata,
   output logic                     busy
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [1:0] MODE_NONE    = 2'b00;
   localparam logic [1:0] MODE_READ    = 2'b01;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   // Elaboration-time guard on the supported parameter ranges.
   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("simple_bus_arbiter: parameter out of supported range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [IDX_W-1:0]   r_win;        // index of the master being served
   logic [IDX_W-1:0]   r_last;       // last master served (round-robin pointer)
   logic               r_sel;        // 0: slave 0 (low half), 1: slave 1
   logic [7:0]         r_bus_addr;
   logic [1:0]         r_bus_mode;
   logic [7:0]         r_bus_wdata;
   logic [7:0]         r_rdata;
   logic               r_err;

   logic [NUM_MASTERS-1:0] w_elig;
   logic                   w_any;
   logic [IDX_W-1:0]       w_pick;
   logic [7:0]             w_pick_addr;
   logic [1:0]             w_pick_mode;
   logic [7:0]             w_pick_wdata;

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]   r_cnt;        // WAIT cycles already spent, minus one
   logic               w_timeout;

   assign w_timeout = (r_cnt == CNT_LAST);
`endif

   // --------------------------------------------------------------------------
   // Request qualification: mode 00 is never eligible.
   // --------------------------------------------------------------------------
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_elig[i] = m_req[i] && (m_mode[2*i +: 2] != MODE_NONE);
      end
   end

   // --------------------------------------------------------------------------
   // Round-robin pick: first eligible index after r_last, wrapping, so the
   // master just served is always considered last.
   // --------------------------------------------------------------------------
   always_comb begin
      int cand;
      cand   = 0;
      w_any  = 1'b0;
      w_pick = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = int'(r_last) + k;
         if (cand >= NUM_MASTERS) begin
            cand = cand - NUM_MASTERS;
         end
         if (!w_any && w_elig[cand[IDX_W-1:0]]) begin
            w_any  = 1'b1;
            w_pick = cand[IDX_W-1:0];
         end
      end
   end

   // Select the winner's request fields (constant slices keep the mux simple).
   always_comb begin
      w_pick_addr  = '0;
      w_pick_mode  = '0;
      w_pick_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_pick == IDX_W'(i)) begin
            w_pick_addr  = m_addr[8*i +: 8];
            w_pick_mode  = m_mode[2*i +: 2];
            w_pick_wdata = m_wdata[8*i +: 8];
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state and Moore outputs
   // --------------------------------------------------------------------------
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      m_gnt        = '0;
      m_done       = '0;
      m_err        = '0;
      bus_start    = '0;
      busy         = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_next_state = S_GRANT;
            end
         end

         S_GRANT: begin
            m_gnt[r_win] = 1'b1;
            // Illegal mode completes with an error and never touches a slave.
            if (r_bus_mode == MODE_ILLEGAL) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_START;
            end
         end

         S_START: begin
            m_gnt[r_win]     = 1'b1;
            bus_start[r_sel] = 1'b1;
            w_next_state     = S_WAIT;
         end

         S_WAIT: begin
            m_gnt[r_win] = 1'b1;
            // Only the selected slave's rdy is honoured.
            if (bus_rdy[r_sel]) begin
               w_next_state = S_DONE;
            end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
            else if (w_timeout) begin
               w_next_state = S_DONE;
            end
`endif
         end

         S_DONE: begin
            m_gnt[r_win]  = 1'b1;
            m_done[r_win] = 1'b1;
            m_err[r_win]  = r_err;
            w_next_state  = S_IDLE;
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Transaction datapath: latched request, result and round-robin pointer.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_win       <= '0;
         r_last      <= IDX_W'(NUM_MASTERS - 1);   // master 0 wins first
         r_sel       <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_mode  <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_win       <= w_pick;
                  r_sel       <= (w_pick_addr >= SPLIT_ADDR);
                  r_bus_addr  <= w_pick_addr;
                  r_bus_mode  <= w_pick_mode;
                  r_bus_wdata <= w_pick_wdata;
                  r_rdata     <= '0;
                  r_err       <= 1'b0;
               end
            end

            S_GRANT: begin
               if (r_bus_mode == MODE_ILLEGAL) begin
                  r_err <= 1'b1;
               end
            end

            S_START: begin
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
               r_cnt <= '0;
`endif
            end

            S_WAIT: begin
               if (bus_rdy[r_sel]) begin
                  // Writes leave the returned data at zero.
                  if (r_bus_mode == MODE_READ) begin
                     r_rdata <= bus_rdata;
                  end
               end
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
               else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end

            S_DONE: begin
               // Served master drops to lowest priority; bus returns to idle zeros.
               r_last      <= r_win;
               r_bus_addr  <= '0;
               r_bus_mode  <= '0;
               r_bus_wdata <= '0;
               r_rdata     <= '0;
               r_err       <= 1'b0;
            end

            default: begin
            end
         endcase
      end
   end

   assign bus_addr  = r_bus_addr;
   assign bus_mode  = r_bus_mode;
   assign bus_wdata = r_bus_wdata;
   assign m_rdata   = r_rdata;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_bus_arbiter
//
// Directed testbench for simple_bus_arbiter (NUM_MASTERS=4). Inputs change on
// the falling edge; outputs are observed on the falling edge, half a cycle away
// from the active rising edge. Expected values are hand-derived constants.
// The timeout scenario is compiled only with SIMPLE_BUS_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_simple_bus_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   m_req;
   logic [8*N-1:0] m_addr;
   logic [2*N-1:0] m_mode;
   logic [8*N-1:0] m_wdata;
   logic [N-1:0]   m_gnt;
   logic [N-1:0]   m_done;
   logic [N-1:0]   m_err;
   logic [7:0]     m_rdata;
   logic [7:0]     bus_addr;
   logic [1:0]     bus_mode;
   logic [7:0]     bus_wdata;
   logic [1:0]     bus_start;
   logic [1:0]     bus_rdy;
   logic [7:0]     bus_rdata;
   logic           busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   simple_bus_arbiter #(
      .NUM_MASTERS   (N),
      .SPLIT_ADDR    (8'd128),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_req    (m_req),
      .m_addr   (m_addr),
      .m_mode   (m_mode),
      .m_wdata  (m_wdata),
      .m_gnt    (m_gnt),
      .m_done   (m_done),
      .m_err    (m_err),
      .m_rdata  (m_rdata),
      .bus_addr (bus_addr),
      .bus_mode (bus_mode),
      .bus_wdata(bus_wdata),
      .bus_start(bus_start),
      .bus_rdy  (bus_rdy),
      .bus_rdata(bus_rdata),
      .busy     (busy)
   );

   // One rising edge, then settle to the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_master(input int i, input logic req, input logic [7:0] addr,
                             input logic [1:0] mode, input logic [7:0] wdata);
      m_req[i]         = req;
      m_addr[8*i +: 8] = addr;
      m_mode[2*i +: 2] = mode;
      m_wdata[8*i +: 8] = wdata;
   endtask

   task automatic clear_inputs();
      m_req     = '0;
      m_addr    = '0;
      m_mode    = '0;
      m_wdata   = '0;
      bus_rdy   = '0;
      bus_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Drives one full non-illegal transaction from an IDLE falling edge with
   // requests already set; the slave answers at the earliest cycle.
   task automatic run_txn(input logic [7:0] rd, output logic [N-1:0] gnt,
                          output logic [N-1:0] done, output logic [7:0] rdata);
      logic [1:0] st;
      tick();                 // GRANT
      gnt = m_gnt;
      tick();                 // START
      st = bus_start;
      tick();                 // WAIT
      bus_rdy   = st;
      bus_rdata = rd;
      tick();                 // DONE
      done      = m_done;
      rdata     = m_rdata;
      bus_rdy   = '0;
      bus_rdata = '0;
      tick();                 // IDLE
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      n_total++;
      if ({m_gnt, m_done, m_err} !== 12'h000)
         $display("FAIL reset_master_outs: got %h want %h", {m_gnt, m_done, m_err}, 12'h000);
      else n_pass++;
      n_total++;
      if ({m_rdata, bus_addr, bus_mode, bus_wdata, bus_start} !== 28'h0)
         $display("FAIL reset_bus_outs: got %h want %h",
                  {m_rdata, bus_addr, bus_mode, bus_wdata, bus_start}, 28'h0);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want %b", busy, 1'b0);
      else n_pass++;
   endtask

   // Masters 0 and 2 request together: 0 wins, 2 follows one cycle after DONE.
   task automatic test_read();
      set_master(0, 1'b1, 8'h05, 2'b01, 8'h00);
      set_master(2, 1'b1, 8'h10, 2'b01, 8'h00);
      tick();                                   // T: sampled -> GRANT
      n_total++;
      if (m_gnt !== 4'b0001) $display("FAIL read_gnt: got %b want %b", m_gnt, 4'b0001);
      else n_pass++;
      n_total++;
      if ({bus_addr, bus_mode} !== {8'h05, 2'b01})
         $display("FAIL read_bus_latch: got %h want %h", {bus_addr, bus_mode}, {8'h05, 2'b01});
      else n_pass++;
      n_total++;
      if (bus_start !== 2'b00) $display("FAIL read_no_early_start: got %b want %b", bus_start, 2'b00);
      else n_pass++;
      bus_rdy   = 2'b01;                        // rdy outside WAIT must be ignored
      bus_rdata = 8'hEE;
      tick();                                   // START
      bus_rdy   = 2'b00;
      bus_rdata = 8'h00;
      n_total++;
      if (bus_start !== 2'b01) $display("FAIL read_start: got %b want %b", bus_start, 2'b01);
      else n_pass++;
      tick();                                   // WAIT
      n_total++;
      if (bus_start !== 2'b00) $display("FAIL read_start_one_cycle: got %b want %b", bus_start, 2'b00);
      else n_pass++;
      bus_rdy   = 2'b01;
      bus_rdata = 8'hA5;
      tick();                                   // DONE
      bus_rdy   = 2'b00;
      bus_rdata = 8'h00;
      n_total++;
      if (m_done !== 4'b0001) $display("FAIL read_done: got %b want %b", m_done, 4'b0001);
      else n_pass++;
      n_total++;
      if (m_rdata !== 8'hA5) $display("FAIL read_rdata: got %h want %h", m_rdata, 8'hA5);
      else n_pass++;
      n_total++;
      if (m_err !== 4'b0000) $display("FAIL read_err: got %b want %b", m_err, 4'b0000);
      else n_pass++;
      set_master(0, 1'b0, 8'h00, 2'b00, 8'h00);
      tick();                                   // IDLE
      n_total++;
      if ({m_gnt, m_done, busy} !== 9'h000)
         $display("FAIL read_idle_after_done: got %h want %h", {m_gnt, m_done, busy}, 9'h000);
      else n_pass++;
      n_total++;
      if ({bus_addr, bus_mode, m_rdata} !== 18'h0)
         $display("FAIL read_bus_cleared: got %h want %h", {bus_addr, bus_mode, m_rdata}, 18'h0);
      else n_pass++;
      tick();                                   // GRANT for master 2
      n_total++;
      if (m_gnt !== 4'b0100) $display("FAIL read_second_gnt: got %b want %b", m_gnt, 4'b0100);
      else n_pass++;
      tick();                                   // START
      tick();                                   // WAIT
      bus_rdy   = 2'b01;
      bus_rdata = 8'h11;
      tick();                                   // DONE
      bus_rdy   = 2'b00;
      bus_rdata = 8'h00;
      n_total++;
      if ({m_done, m_rdata} !== {4'b0100, 8'h11})
         $display("FAIL read_second_done: got %h want %h", {m_done, m_rdata}, {4'b0100, 8'h11});
      else n_pass++;
      set_master(2, 1'b0, 8'h00, 2'b00, 8'h00);
      tick();                                   // IDLE
   endtask

   // Master 1 writes to the upper half; a stray rdy from slave 0 is ignored.
   task automatic test_decode_write();
      do_reset();
      set_master(1, 1'b1, 8'h80, 2'b10, 8'h3C);
      tick();                                   // GRANT
      n_total++;
      if ({m_gnt, bus_addr, bus_mode, bus_wdata} !== {4'b0010, 8'h80, 2'b10, 8'h3C})
         $display("FAIL write_latch: got %h want %h", {m_gnt, bus_addr, bus_mode, bus_wdata},
                  {4'b0010, 8'h80, 2'b10, 8'h3C});
      else n_pass++;
      set_master(1, 1'b1, 8'h01, 2'b01, 8'hFF); // changes after sampling are ignored
      tick();                                   // START
      n_total++;
      if (bus_start !== 2'b10) $display("FAIL write_start_slave1: got %b want %b", bus_start, 2'b10);
      else n_pass++;
      tick();                                   // WAIT
      bus_rdy   = 2'b01;                        // wrong slave
      bus_rdata = 8'h99;
      tick();                                   // still WAIT
      n_total++;
      if ({m_done, m_gnt, busy} !== {4'b0000, 4'b0010, 1'b1})
         $display("FAIL write_stray_rdy: got %h want %h", {m_done, m_gnt, busy},
                  {4'b0000, 4'b0010, 1'b1});
      else n_pass++;
      n_total++;
      if ({bus_addr, bus_wdata} !== {8'h80, 8'h3C})
         $display("FAIL write_bus_stable: got %h want %h", {bus_addr, bus_wdata}, {8'h80, 8'h3C});
      else n_pass++;
      bus_rdy   = 2'b10;
      bus_rdata = 8'h77;
      tick();                                   // DONE
      bus_rdy   = 2'b00;
      bus_rdata = 8'h00;
      n_total++;
      if ({m_done, m_err, m_rdata} !== {4'b0010, 4'b0000, 8'h00})
         $display("FAIL write_done: got %h want %h", {m_done, m_err, m_rdata},
                  {4'b0010, 4'b0000, 8'h00});
      else n_pass++;
      set_master(1, 1'b0, 8'h00, 2'b00, 8'h00);
      tick();                                   // IDLE
      n_total++;
      if (bus_wdata !== 8'h00) $display("FAIL write_idle_wdata: got %h want %h", bus_wdata, 8'h00);
      else n_pass++;
   endtask

   // All four masters hold reads: order 0,1,2,3,0, back to back.
   task automatic test_round_robin();
      logic [N-1:0] gnt, done;
      logic [7:0]   rdata;
      logic [N-1:0] exp_order [5];
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      set_master(0, 1'b1, 8'h01, 2'b01, 8'h00);
      set_master(1, 1'b1, 8'h90, 2'b01, 8'h00);
      set_master(2, 1'b1, 8'h02, 2'b01, 8'h00);
      set_master(3, 1'b1, 8'hF0, 2'b01, 8'h00);
      for (int k = 0; k < 5; k++) begin
         run_txn(8'h40 + 8'(k), gnt, done, rdata);
         n_total++;
         if ({gnt, done} !== {exp_order[k], exp_order[k]})
            $display("FAIL rr_order_%0d: got %b want %b", k, {gnt, done}, {exp_order[k], exp_order[k]});
         else n_pass++;
         n_total++;
         if (rdata !== 8'h40 + 8'(k))
            $display("FAIL rr_rdata_%0d: got %h want %h", k, rdata, 8'h40 + 8'(k));
         else n_pass++;
      end
      clear_inputs();
   endtask

   // Master 2 requests with mode 00 and is skipped.
   task automatic test_mode_none();
      logic [N-1:0] gnt, done;
      logic [7:0]   rdata;
      logic [N-1:0] exp_order [4];
      exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      do_reset();
      set_master(0, 1'b1, 8'h03, 2'b01, 8'h00);
      set_master(1, 1'b1, 8'h04, 2'b01, 8'h00);
      set_master(2, 1'b1, 8'h05, 2'b00, 8'h00);
      set_master(3, 1'b1, 8'hC0, 2'b01, 8'h00);
      for (int k = 0; k < 4; k++) begin
         run_txn(8'h60 + 8'(k), gnt, done, rdata);
         n_total++;
         if (gnt !== exp_order[k])
            $display("FAIL mode00_order_%0d: got %b want %b", k, gnt, exp_order[k]);
         else n_pass++;
      end
      clear_inputs();
   endtask

   // Mode 11: no slave start, error completion two cycles after sampling.
   task automatic test_illegal_mode();
      do_reset();
      set_master(3, 1'b1, 8'h20, 2'b11, 8'h55);
      tick();                                   // GRANT
      n_total++;
      if ({m_gnt, bus_start} !== {4'b1000, 2'b00})
         $display("FAIL illegal_grant: got %b want %b", {m_gnt, bus_start}, {4'b1000, 2'b00});
      else n_pass++;
      tick();                                   // DONE
      set_master(3, 1'b0, 8'h00, 2'b00, 8'h00);
      n_total++;
      if ({m_done, m_err, bus_start} !== {4'b1000, 4'b1000, 2'b00})
         $display("FAIL illegal_done_err: got %b want %b", {m_done, m_err, bus_start},
                  {4'b1000, 4'b1000, 2'b00});
      else n_pass++;
      tick();                                   // IDLE
      n_total++;
      if ({m_err, m_done, busy} !== 9'h000)
         $display("FAIL illegal_idle: got %h want %h", {m_err, m_done, busy}, 9'h000);
      else n_pass++;
   endtask

   // Reset during WAIT aborts without a done pulse.
   task automatic test_reset_mid_txn();
      do_reset();
      set_master(0, 1'b1, 8'h05, 2'b01, 8'h00);
      tick();                                   // GRANT
      tick();                                   // START
      tick();                                   // WAIT
      n_total++;
      if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want %b", busy, 1'b1);
      else n_pass++;
      rst_n   = 1'b0;
      bus_rdy = 2'b01;
      tick();
      set_master(0, 1'b0, 8'h00, 2'b00, 8'h00);
      n_total++;
      if ({busy, m_gnt, m_done, bus_addr} !== 17'h0)
         $display("FAIL midrst_abort: got %h want %h", {busy, m_gnt, m_done, bus_addr}, 17'h0);
      else n_pass++;
      rst_n   = 1'b1;
      bus_rdy = 2'b00;
      tick();
      n_total++;
      if ({busy, m_done} !== 5'h0)
         $display("FAIL midrst_no_done: got %h want %h", {busy, m_done}, 5'h0);
      else n_pass++;
   endtask

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
   // Slave never answers: error after 64 WAIT cycles, then master 1 is served.
   task automatic test_timeout();
      int cyc;
      do_reset();
      set_master(0, 1'b1, 8'h10, 2'b01, 8'h00);
      set_master(1, 1'b1, 8'h20, 2'b01, 8'h00);
      tick();                                   // GRANT
      tick();                                   // START
      tick();                                   // first WAIT cycle
      cyc = 0;
      while (m_done == '0 && cyc < 200) begin
         cyc++;
         tick();
      end
      n_total++;
      if (cyc !== 64) $display("FAIL timeout_wait_cycles: got %0d want %0d", cyc, 64);
      else n_pass++;
      n_total++;
      if ({m_done, m_err, m_rdata} !== {4'b0001, 4'b0001, 8'h00})
         $display("FAIL timeout_err: got %h want %h", {m_done, m_err, m_rdata},
                  {4'b0001, 4'b0001, 8'h00});
      else n_pass++;
      set_master(0, 1'b0, 8'h00, 2'b00, 8'h00);
      tick();                                   // IDLE
      tick();                                   // GRANT for master 1
      n_total++;
      if (m_gnt !== 4'b0010) $display("FAIL timeout_next_gnt: got %b want %b", m_gnt, 4'b0010);
      else n_pass++;
      tick();                                   // START
      tick();                                   // WAIT
      bus_rdy = 2'b01;
      tick();                                   // DONE
      bus_rdy = 2'b00;
      set_master(1, 1'b0, 8'h00, 2'b00, 8'h00);
      tick();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_read();
      test_decode_write();
      test_round_robin();
      test_mode_none();
      test_illegal_mode();
      test_reset_mid_txn();
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
